// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter slice.
package counter_pkg;

  localparam bit CNT_WRAP = 1'b0;
  localparam bit CNT_SAT  = 1'b1;

  // Bits needed to hold values 0..v-1; callers guarantee v >= 2.
  function automatic int clog2(input longint unsigned v);
    longint unsigned x;
    int r;
    r = 0;
    x = v - 64'd1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Enable prescaler: raises Tick on every DIV-th enabled cycle.
module prescaler
  import counter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic Clk,
  input  logic Clr,
  input  logic En,
  input  logic Sync_clr,
  output logic Tick
);

  generate
    if (DIV == 1) begin : g_bypass
      logic unused_pre;
      assign unused_pre = ^{Clk, Clr, Sync_clr};
      assign Tick = En;
    end else begin : g_div
      localparam int PW = clog2(DIV);
      localparam logic [PW-1:0] LAST = PW'(DIV - 1);
      logic [PW-1:0] p;

      assign Tick = En & (p == LAST);

      always_ff @(posedge Clk) begin
        if (!Clr)          p <= '0;
        else if (Sync_clr) p <= '0;
        else if (En)       p <= Tick ? '0 : p + 1'b1;
      end
    end
  endgenerate

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo-N counter with load clamp, prescaled enable, wrap/saturate bound.
module mod_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 16,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter int              PRESCALE = 1,
  parameter bit              SATURATE = CNT_WRAP
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Wrap
);

  // Top count expressed in WIDTH bits; all-ones when MODULUS == 2**WIDTH.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

  logic             tick;
  logic [WIDTH-1:0] bound;
  logic             at_bound;

  prescaler #(.DIV(PRESCALE)) u_pre (
    .Clk      (Clk),
    .Clr      (Clr),
    .En       (En),
    .Sync_clr (Load),
    .Tick     (tick)
  );

  assign bound    = Up ? MAX_Q : '0;
  assign at_bound = (Q == bound);
  assign TC       = En & tick & at_bound;

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      Q    <= '0;
      Wrap <= 1'b0;
    end else if (Load) begin
      Q    <= (D > MAX_Q) ? MAX_Q : D;
      Wrap <= 1'b0;
    end else if (tick) begin
      if (at_bound) begin
        if (SATURATE != CNT_SAT) Q <= Up ? '0 : MAX_Q;
        Wrap <= 1'b1;
      end else begin
        Q    <= Up ? Q + 1'b1 : Q - 1'b1;
        Wrap <= 1'b0;
      end
    end else begin
      Wrap <= 1'b0;
    end
  end

endmodule
